// File: rtl/gpu_frame_pkg.sv
// Frame-bus definitions shared by the scheduler and the per-core frame receiver:
// header word layout, field slices and the receiver state encoding.
package gpu_frame_pkg;

    localparam int FRAME_WORDS   = 16;
    localparam int HDR_CTRL      = 0;
    localparam int HDR_CORE_MASK = 1;
    localparam int HDR_R0_MASK   = 2;
    localparam int HDR_R0_BASE   = 8;

    localparam int IF_NUM_LSB = 0;
    localparam int IF_NUM_W   = 2;
    localparam int FENCE_LSB  = 2;
    localparam int FENCE_W    = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        R0    = 3'd2,
        INSTR = 3'd3,
        SKIP  = 3'd4,
        DONE  = 3'd5,
        RUN   = 3'd6
    } rx_state_t;

    function automatic logic [IF_NUM_W-1:0] hdr_if_num(input logic [15:0] word0);
        return word0[IF_NUM_LSB +: IF_NUM_W];
    endfunction

    function automatic logic [FENCE_W-1:0] hdr_fence(input logic [15:0] word0);
        return word0[FENCE_LSB +: FENCE_W];
    endfunction

endpackage

// File: rtl/core_frame_receiver_frame_word_counter.sv
// Word-in-frame (wc) and frame (fc) counters for the frame receiver.
// A clear with a simultaneous advance starts a new stream at wc=1, fc=0.
module frame_word_counter
    import gpu_frame_pkg::*;
#(
    parameter int N_WORDS = FRAME_WORDS,
    parameter int FC_W    = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_clear,
    input  logic                       i_advance,
    output logic [$clog2(N_WORDS)-1:0] o_wc,
    output logic [FC_W-1:0]            o_fc,
    output logic                       o_wc_last
);

    localparam int WCW = $clog2(N_WORDS);

    logic [WCW-1:0]  r_wc;
    logic [FC_W-1:0] r_fc;

    // wc/fc advance on accepted words only; wc wrap bumps the frame count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wc <= {WCW{1'b0}};
            r_fc <= {FC_W{1'b0}};
        end else if (i_clear) begin
            r_wc <= i_advance ? WCW'(1) : {WCW{1'b0}};
            r_fc <= {FC_W{1'b0}};
        end else if (i_advance) begin
            if (o_wc_last) begin
                r_wc <= {WCW{1'b0}};
                r_fc <= r_fc + FC_W'(1);
            end else begin
                r_wc <= r_wc + WCW'(1);
            end
        end
    end

    assign o_wc      = r_wc;
    assign o_fc      = r_fc;
    assign o_wc_last = (r_wc == WCW'(N_WORDS - 1));

endmodule

// File: rtl/core_frame_receiver.sv
// Per-core consumer of the scheduler frame bus: parses the control frame, loads
// instruction frames into IMEM and hands off to the core. Optional: CORE_RX_PROTOCOL_CHECK_EN.
module core_frame_receiver
    import gpu_frame_pkg::*;
#(
    parameter int CORE_ID     = 0,
    parameter int CORE_NUM    = 16,
    parameter int BUS_TO_CORE = 16,
    parameter int INSTR_SIZE  = 16,
    parameter int FRAME_WORDS = gpu_frame_pkg::FRAME_WORDS,
    parameter int R0_DEPTH    = 8,
    parameter int IMEM_DEPTH  = 256
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          frame_valid,
    input  logic [BUS_TO_CORE-1:0]        frame_data,
    output logic                          core_reading,
    output logic                          core_ready,
    input  logic                          core_done,
    output logic                          imem_we,
    output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
    output logic [INSTR_SIZE-1:0]         imem_wdata,
    output logic [R0_DEPTH*16-1:0]        r0_preload,
    output logic [R0_DEPTH-1:0]           r0_preload_mask,
    output logic [1:0]                    fence,
    output logic [$clog2(IMEM_DEPTH):0]   instr_count,
    output logic                          prog_start
`ifdef CORE_RX_PROTOCOL_CHECK_EN
    ,
    output logic                          rx_err
`endif
);

    localparam int AW   = $clog2(IMEM_DEPTH);
    localparam int CW   = AW + 1;
    localparam int WCW  = $clog2(FRAME_WORDS);
    localparam int FC_W = 3;

    rx_state_t         r_state;
    logic [1:0]        r_if_num;
    logic [1:0]        r_fence_hdr;
    logic              r_sel;
    logic [WCW-1:0]    w_wc;
    logic [FC_W-1:0]   w_fc;
    logic              w_wc_last;
    logic              w_xfer;
    logic              w_last_instr;
    logic              w_cnt_clear;
    logic [CORE_NUM-1:0] w_core_mask;

    assign w_xfer       = frame_valid && core_reading;
    assign w_last_instr = w_wc_last && (w_fc == {1'b0, r_if_num});
    assign w_cnt_clear  = (r_state == IDLE) || (r_state == DONE) || (r_state == RUN);
    assign w_core_mask  = frame_data[CORE_NUM-1:0];

    frame_word_counter #(
        .N_WORDS (FRAME_WORDS),
        .FC_W    (FC_W)
    ) u_wcnt (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_cnt_clear),
        .i_advance (w_xfer),
        .o_wc      (w_wc),
        .o_fc      (w_fc),
        .o_wc_last (w_wc_last)
    );

`ifdef CORE_RX_PROTOCOL_CHECK_EN
    logic r_low_seen;
    logic w_err_event;

    // Remembers one idle bus cycle inside a frame; a second one is a protocol error
    always_ff @(posedge clk) begin
        if (reset) begin
            r_low_seen <= 1'b0;
        end else begin
            r_low_seen <= core_reading && (w_wc != {WCW{1'b0}}) && !frame_valid;
        end
    end

    assign w_err_event = (core_reading && (w_wc != {WCW{1'b0}}) && !frame_valid && r_low_seen)
                       || ((r_state == RUN) && frame_valid)
                       || ((r_state == INSTR) && w_xfer && (instr_count == CW'(IMEM_DEPTH)));
`endif

    // Receiver FSM; every output is a register updated here
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= IDLE;
            r_if_num        <= 2'd0;
            r_fence_hdr     <= 2'd0;
            r_sel           <= 1'b0;
            core_ready      <= 1'b1;
            core_reading    <= 1'b1;
            imem_we         <= 1'b0;
            imem_addr       <= {AW{1'b0}};
            imem_wdata      <= {INSTR_SIZE{1'b0}};
            r0_preload      <= {(R0_DEPTH*16){1'b0}};
            r0_preload_mask <= {R0_DEPTH{1'b0}};
            fence           <= 2'd0;
            instr_count     <= {CW{1'b0}};
            prog_start      <= 1'b0;
`ifdef CORE_RX_PROTOCOL_CHECK_EN
            rx_err          <= 1'b0;
`endif
        end else begin
            imem_we    <= 1'b0;
            prog_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_xfer && (w_wc == WCW'(HDR_CTRL))) begin
                        r_if_num    <= hdr_if_num(frame_data[15:0]);
                        r_fence_hdr <= hdr_fence(frame_data[15:0]);
                        r_state     <= HDR;
                    end
                end
                HDR: begin
                    if (w_xfer) begin
                        if (w_wc == WCW'(HDR_CORE_MASK)) begin
                            r_sel <= w_core_mask[CORE_ID];
                            if (w_core_mask[CORE_ID]) begin
                                instr_count <= {CW{1'b0}};
                                fence       <= r_fence_hdr;
                            end
                        end
                        if ((w_wc == WCW'(HDR_R0_MASK)) && r_sel) begin
                            r0_preload_mask <= frame_data[R0_DEPTH-1:0];
                        end
                        if (w_wc == WCW'(HDR_R0_BASE - 1)) begin
                            r_state <= R0;
                        end
                    end
                end
                R0: begin
                    if (w_xfer) begin
                        if (r_sel) begin
                            r0_preload[(int'(w_wc) - HDR_R0_BASE)*16 +: 16] <= frame_data[15:0];
                        end
                        if (w_wc_last) begin
                            if (r_if_num == 2'd0) begin
                                r_state      <= DONE;
                                core_reading <= 1'b0;
                            end else if (r_sel) begin
                                r_state <= INSTR;
                            end else begin
                                r_state <= SKIP;
                            end
                        end
                    end
                end
                INSTR: begin
                    if (w_xfer) begin
                        if (instr_count < CW'(IMEM_DEPTH)) begin
                            imem_we     <= 1'b1;
                            imem_addr   <= instr_count[AW-1:0];
                            imem_wdata  <= frame_data[INSTR_SIZE-1:0];
                            instr_count <= instr_count + CW'(1);
                        end
                        if (w_last_instr) begin
                            r_state      <= DONE;
                            prog_start   <= 1'b1;
                            core_reading <= 1'b0;
                            core_ready   <= 1'b0;
                        end
                    end
                end
                SKIP: begin
                    if (w_xfer && w_last_instr) begin
                        r_state <= IDLE;
                    end
                end
                DONE: begin
                    // if_num==0 headers pass through DONE without a pulse and drop back to IDLE
                    r_state      <= (r_if_num == 2'd0) ? IDLE : RUN;
                    core_reading <= (r_if_num == 2'd0);
                end
                RUN: begin
                    if (core_done) begin
                        r_state      <= IDLE;
                        core_ready   <= 1'b1;
                        core_reading <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    core_ready   <= 1'b1;
                    core_reading <= 1'b1;
                end
            endcase
`ifdef CORE_RX_PROTOCOL_CHECK_EN
            if (w_err_event) begin
                rx_err       <= 1'b1;
                r_state      <= IDLE;
                prog_start   <= 1'b0;
                core_ready   <= 1'b1;
                core_reading <= 1'b1;
            end else if ((r_state == IDLE) && w_xfer) begin
                rx_err <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: doc/core_frame_receiver.md
Name: core_frame_receiver

Overview:
- Core-side receiver for the scheduler's per-core frame bus. The scheduler streams a program as 16-bit words; this block is the consumer end of that stream.
- Parses the 16-word control frame (fence, frame count, masks, R0 preload data).
- Writes the following instruction frames into the core's instruction memory, then hands the program to the core and blocks until the core reports completion.
- One instance per core, between the scheduler bus and the core pipeline.

Parameters:
- CORE_ID, 0, index of this core; selects its bit in the core mask.
- CORE_NUM, 16, number of cores; width of the core mask.
- BUS_TO_CORE, 16, bus word width, equal to INSTR_SIZE.
- INSTR_SIZE, 16, instruction width.
- FRAME_WORDS, 16, words per frame (FRAME_SIZE 256 / 16).
- R0_DEPTH, 8, number of R0 preload words (header words 8..15).
- IMEM_DEPTH, 256, instruction memory depth in words.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- frame_valid  in  1  scheduler presents frame_data
- frame_data  in  BUS_TO_CORE  current frame word
- core_reading  out  1  ready; a word transfers when frame_valid && core_reading
- core_ready  out  1  core idle, may be sent a new program
- core_done  in  1  core finished the program (READY opcode retired)
- imem_we  out  1  instruction write strobe
- imem_addr  out  $clog2(IMEM_DEPTH)  instruction write address
- imem_wdata  out  INSTR_SIZE  instruction word
- r0_preload  out  R0_DEPTH*16  latched R0 data; word k in bits [16k+15:16k]
- r0_preload_mask  out  R0_DEPTH  header word2[R0_DEPTH-1:0]
- fence  out  2  header word0[3:2]
- instr_count  out  $clog2(IMEM_DEPTH)+1  number of instructions loaded
- prog_start  out  1  one-cycle pulse: program loaded, core may start

Behaviour:
- Reset: state IDLE.
  - core_ready=1, core_reading=1.
  - imem_we=0, imem_addr=0, imem_wdata=0.
  - r0_preload=0, r0_preload_mask=0, fence=0, instr_count=0, prog_start=0.
- Reset asserted in any state, including mid-frame, wins over all other events and returns to this state next edge. Partially written imem content is don't-care.
- Word counter wc (0..15) and frame counter fc: both clear in IDLE and advance only on a transfer. wc wraps 15->0 and fc increments on each wrap.
- Header format:
  - word0: [1:0]=if_num (instruction frames following), [3:2]=fence, [15:4] ignored.
  - word1: core mask; word2: R0 mask; words 3..7 reserved and ignored.
  - words 8..15: R0 data.
- IDLE: a transfer captures word0 -> HDR.
- HDR (wc 1..7):
  - At wc=1, sel = word1[CORE_ID] is latched.
  - At wc=2, r0_preload_mask is captured, gated by sel.
  - At wc=7 -> R0.
- R0 (wc 8..15): if sel, word wc-8 is stored into r0_preload. At wc=15 the next state is:
  - INSTR if if_num!=0 and sel;
  - SKIP if if_num!=0 and !sel;
  - DONE if if_num==0.
- INSTR: each transfer produces a registered write on the next cycle: imem_we=1, imem_addr=instr_count, imem_wdata=word; instr_count increments. After the final word (fc==if_num, wc==15) -> DONE.
- SKIP: consumes the same number of words with no writes and no output changes -> IDLE. core_ready stays 1 throughout.
- DONE: prog_start=1 for exactly one cycle, simultaneous with the last imem write -> RUN. For if_num==0 (selected or not) no pulse is issued: go to IDLE and discard the captured header.
- RUN:
  - core_ready=0, core_reading=0; the scheduler must not send.
  - core_done=1 -> IDLE next cycle; instr_count and r0_preload hold until the next selected header.
  - core_done outside RUN is ignored.
- core_reading is 1 in IDLE, HDR, R0, INSTR and SKIP. frame_valid low simply stalls; no timeout.
- Throughput: one word per cycle. Latency from last accepted word to prog_start is 1 cycle.
- If instr_count would reach IMEM_DEPTH, further writes are dropped (imem_we=0); the counter saturates.

Optional Feature:
- Macro: CORE_RX_PROTOCOL_CHECK_EN.
- When defined:
  - Adds output rx_err (1 bit, reset 0). It is sticky and cleared only by reset or on the next IDLE header accept.
  - Set on: frame_valid dropping mid-frame (wc!=0) for more than 1 cycle; frame_valid asserted during RUN; IMEM overflow.
  - With an error, prog_start is suppressed and the block returns to IDLE.
- When undefined: no port, no checks, behaviour exactly as above.

Decomposition:
- Package gpu_frame_pkg:
  - FRAME_WORDS, header word indices (HDR_CTRL=0, HDR_CORE_MASK=1, HDR_R0_MASK=2, HDR_R0_BASE=8);
  - field slices for if_num and fence;
  - rx_state_t enum (IDLE, HDR, R0, INSTR, SKIP, DONE, RUN).
- Package is shared with the scheduler.
- One natural sub-module: frame_word_counter (wc/fc counters, wrap and last-word flags).

Test Plan:
- Header {word0=0x0002, word1=0x0f0f, word2=0x0f00} plus 32 instructions to CORE_ID=0 -> 32 imem writes to addr 0..31, prog_start one cycle after the 48th transfer, instr_count=32, core_ready=0.
- Same stream to CORE_ID=4 (mask bit 0) -> no imem_we, no prog_start, core_ready=1 throughout, next header accepted normally.
- R0 words 8..15 = 0x1111..0x8888, word2=0x00ff -> r0_preload[15:0]=0x1111, r0_preload[127:112]=0x8888, r0_preload_mask=0xff.
- frame_valid toggled 1010..., with core_reading held 1 -> identical imem contents and order; prog_start delayed only by the stall count.
- Reset pulsed at instruction word 20 -> all outputs at reset values next cycle; a full reload then gives instr_count=32.
- In RUN, pulse core_done -> core_ready=1 next cycle; a second program loads with addresses restarting at 0.
